// File: rtl/mpu_store_if.sv
// rtl/mpu_store_if.sv - request, register-file read and element stream bundle for mpu_store
interface mpu_store_if #(
  parameter int FP              = 32,
  parameter int M               = 4,
  parameter int N               = 4,
  parameter int MBITS           = $clog2(M),
  parameter int NBITS           = $clog2(N),
  parameter int MATRIX_REG_SIZE = 2
);
  logic                       en;
  logic [MATRIX_REG_SIZE-1:0] store_addr;
  logic [MBITS:0]             matrix_m_size;
  logic [NBITS:0]             matrix_n_size;
  logic                       ack;
  logic                       error;
  logic                       done;
  logic                       reg_read_en;
  logic [MATRIX_REG_SIZE-1:0] reg_store_addr;
  logic [MBITS:0]             reg_m_out;
  logic [NBITS:0]             reg_n_out;
  logic [FP-1:0]              reg_element_in;
  logic [FP-1:0]              element_out;
  logic [MBITS:0]             element_m;
  logic [NBITS:0]             element_n;
  logic                       element_last;
  logic                       valid;
  logic                       ready;

  modport slave (
    input  en, store_addr, matrix_m_size, matrix_n_size, reg_element_in, ready,
    output ack, error, done, reg_read_en, reg_store_addr, reg_m_out, reg_n_out,
           element_out, element_m, element_n, element_last, valid
  );

  modport master (
    output en, store_addr, matrix_m_size, matrix_n_size, reg_element_in, ready,
    input  ack, error, done, reg_read_en, reg_store_addr, reg_m_out, reg_n_out,
           element_out, element_m, element_n, element_last, valid
  );
endinterface

// File: rtl/mpu_store.sv
// rtl/mpu_store.sv - streams an m x n matrix out of the register file in row-major order
module mpu_store #(
  parameter int FP              = 32,
  parameter int M               = 4,
  parameter int N               = 4,
  parameter int MBITS           = $clog2(M),
  parameter int NBITS           = $clog2(N),
  parameter int MATRIX_REG_SIZE = 2
) (
  input logic       clk,
  input logic       rst,
  mpu_store_if.slave bus
);
  typedef enum logic [1:0] {STORE_IDLE, STORE_READ, STORE_DRAIN} state_t;

  localparam logic [MBITS:0] M_MAX   = (MBITS+1)'(M);
  localparam logic [NBITS:0] N_MAX   = (NBITS+1)'(N);
  localparam logic [MBITS:0] ROW_ONE = (MBITS+1)'(1);
  localparam logic [NBITS:0] COL_ONE = (NBITS+1)'(1);

  state_t                     state, state_next;
  logic [MBITS:0]             m_last, row;
  logic [NBITS:0]             n_last, col;
  logic [MATRIX_REG_SIZE-1:0] addr_q;
  logic                       error_q, done_q;
  logic                       inflight, inflight_last;
  logic [MBITS:0]             inflight_m;
  logic [NBITS:0]             inflight_n;
  logic [FP-1:0]              fifo_data [2];
  logic [MBITS:0]             fifo_m    [2];
  logic [NBITS:0]             fifo_n    [2];
  logic                       fifo_last [2];
  logic                       rd_ptr, wr_ptr;
  logic [1:0]                 count;
  logic                       size_ok, accept, reject, issue, ack_c;
  logic                       pop, push, last_issue, buf_room;
  logic [2:0]                 pending;

  assign size_ok = (bus.matrix_m_size != '0) && (bus.matrix_n_size != '0) &&
                   (bus.matrix_m_size <= M_MAX) && (bus.matrix_n_size <= N_MAX);
  assign pop        = (count != 2'd0) && bus.ready;
  assign push       = inflight;
  assign last_issue = (row == m_last) && (col == n_last);
  // Reads are throttled so buffered plus in-flight elements never exceed two.
  assign pending    = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign buf_room   = pending < 3'd2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STORE_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ack_c      = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    issue      = 1'b0;
    case (state)
      STORE_IDLE: begin
        if (bus.en) begin
          if (size_ok) begin
            accept     = 1'b1;
            ack_c      = 1'b1;
            state_next = STORE_READ;
          end else begin
            reject = 1'b1;
          end
        end
      end
      STORE_READ: begin
        if (buf_room) begin
          issue = 1'b1;
          if (last_issue) state_next = STORE_DRAIN;
        end
      end
      STORE_DRAIN: begin
        if (pop && fifo_last[rd_ptr]) state_next = STORE_IDLE;
      end
      default: state_next = STORE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last        <= '0;
      n_last        <= '0;
      row           <= '0;
      col           <= '0;
      addr_q        <= '0;
      error_q       <= 1'b0;
      done_q        <= 1'b0;
      inflight      <= 1'b0;
      inflight_m    <= '0;
      inflight_n    <= '0;
      inflight_last <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_m[i]    <= '0;
        fifo_n[i]    <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (accept) begin
        addr_q  <= bus.store_addr;
        m_last  <= bus.matrix_m_size - ROW_ONE;
        n_last  <= bus.matrix_n_size - COL_ONE;
        row     <= '0;
        col     <= '0;
        error_q <= 1'b0;
      end else if (reject) begin
        error_q <= 1'b1;
      end
      if (issue) begin
        if (col == n_last) begin
          col <= '0;
          row <= row + ROW_ONE;
        end else begin
          col <= col + COL_ONE;
        end
      end
      inflight      <= issue;
      inflight_m    <= row;
      inflight_n    <= col;
      inflight_last <= last_issue;
      done_q        <= (state == STORE_DRAIN) && pop && fifo_last[rd_ptr];
      if (push) begin
        fifo_data[wr_ptr] <= bus.reg_element_in;
        fifo_m[wr_ptr]    <= inflight_m;
        fifo_n[wr_ptr]    <= inflight_n;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == 2'd2));

  assign bus.ack            = ack_c;
  assign bus.error          = error_q;
  assign bus.done           = done_q;
  assign bus.reg_read_en    = issue;
  assign bus.reg_store_addr = addr_q;
  assign bus.reg_m_out      = row;
  assign bus.reg_n_out      = col;
  assign bus.element_out    = fifo_data[rd_ptr];
  assign bus.element_m      = fifo_m[rd_ptr];
  assign bus.element_n      = fifo_n[rd_ptr];
  assign bus.element_last   = fifo_last[rd_ptr];
  assign bus.valid          = count != 2'd0;
endmodule
